// File: rtl/ctrl_pipe_pkg.sv
// Shared widths, link register and stage-register layouts for the ID->WB control pipe.
package ctrl_pipe_pkg;
  localparam int REG_W = 5;
  localparam int OPC_W = 6;
  localparam logic [REG_W-1:0] LINK_REG = 5'd31;

  // ID/EX control register
  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dst;
  } ex_ctrl_t;

  // EX/MEM control register
  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic [REG_W-1:0] dst;
  } mem_ctrl_t;

  // MEM/WB control register
  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] dst;
  } wb_ctrl_t;

  // JAL always links into LINK_REG; otherwise regDst picks rd (R-type) over rt (I-type).
  function automatic logic [REG_W-1:0] resolve_dst(input logic no_dest, input logic reg_dst,
                                                   input logic [REG_W-1:0] rd,
                                                   input logic [REG_W-1:0] rt);
    return no_dest ? LINK_REG : (reg_dst ? rd : rt);
  endfunction
endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle between Control/IF-ID front end (master) and the control pipe (slave).
interface ctrl_pipe_if;
  import ctrl_pipe_pkg::*;

  logic             ext_stall;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             id_uses_rt;
  logic             id_regWrite, id_memToReg, id_branch, id_memRead;
  logic             id_memWrite, id_ALUsrc, id_regDst, id_noDest;
  logic [OPC_W-1:0] id_opcode;

  logic             stall;
  logic             ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc;
  logic [OPC_W-1:0] ex_opcode;
  logic [REG_W-1:0] ex_dst;
  logic             mem_regWrite, mem_memToReg, mem_memRead, mem_memWrite;
  logic [REG_W-1:0] mem_dst;
  logic             wb_regWrite, wb_memToReg;
  logic [REG_W-1:0] wb_dst;

  modport master (
    output ext_stall, id_valid, id_rs, id_rt, id_rd, id_uses_rt,
           id_regWrite, id_memToReg, id_branch, id_memRead,
           id_memWrite, id_ALUsrc, id_regDst, id_noDest, id_opcode,
    input  stall,
           ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc, ex_opcode, ex_dst,
           mem_regWrite, mem_memToReg, mem_memRead, mem_memWrite, mem_dst,
           wb_regWrite, wb_memToReg, wb_dst
  );

  modport slave (
    input  ext_stall, id_valid, id_rs, id_rt, id_rd, id_uses_rt,
           id_regWrite, id_memToReg, id_branch, id_memRead,
           id_memWrite, id_ALUsrc, id_regDst, id_noDest, id_opcode,
    output stall,
           ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc, ex_opcode, ex_dst,
           mem_regWrite, mem_memToReg, mem_memRead, mem_memWrite, mem_dst,
           wb_regWrite, wb_memToReg, wb_dst
  );
endinterface

// File: rtl/ctrl_pipe_hazard_detect.sv
// Combinational load-use / branch-compare hazard detection for the ID instruction.
module hazard_detect
  import ctrl_pipe_pkg::*;
(
  input  logic             id_valid,
  input  logic             ext_stall,
  input  logic             id_branch,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  output logic             stall
);
  logic ex_match, mem_match, h1, h2, h3;

  // $0 is hard-wired, so a producer targeting it never creates a dependency.
  always_comb begin
    ex_match  = (ex_dst != '0)  && ((ex_dst == id_rs)  || (id_uses_rt && ex_dst == id_rt));
    mem_match = (mem_dst != '0) && ((mem_dst == id_rs) || (id_uses_rt && mem_dst == id_rt));
    h1 = ex_mem_read && ex_match;
    h2 = id_branch && ex_reg_write && !ex_mem_read && ex_match;
    h3 = id_branch && ((ex_mem_read && ex_match) || (mem_mem_read && mem_match));
    // ext_stall already freezes the front end, so no hazard stall is raised on top of it.
    stall = id_valid && (h1 || h2 || h3) && !ext_stall;
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ID-stage control capture plus ID/EX, EX/MEM, MEM/WB control registers with hazard stall.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);
  ex_ctrl_t         id_ctrl, ex_q;
  mem_ctrl_t        mem_q;
  wb_ctrl_t         wb_q;
  logic [REG_W-1:0] id_dst;
  logic             stall;

  // Build the ID/EX candidate; a write to $0 is squashed here so later stages never see it.
  always_comb begin
    id_dst             = resolve_dst(bus.id_noDest, bus.id_regDst, bus.id_rd, bus.id_rt);
    id_ctrl            = '0;
    id_ctrl.reg_write  = bus.id_regWrite && (id_dst != '0);
    id_ctrl.mem_to_reg = bus.id_memToReg;
    id_ctrl.mem_read   = bus.id_memRead;
    id_ctrl.mem_write  = bus.id_memWrite;
    id_ctrl.alu_src    = bus.id_ALUsrc;
    id_ctrl.opcode     = bus.id_opcode;
    id_ctrl.dst        = id_dst;
  end

  hazard_detect u_hazard (
    .id_valid     (bus.id_valid),
    .ext_stall    (bus.ext_stall),
    .id_branch    (bus.id_branch),
    .id_uses_rt   (bus.id_uses_rt),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .ex_mem_read  (ex_q.mem_read),
    .ex_reg_write (ex_q.reg_write),
    .ex_dst       (ex_q.dst),
    .mem_mem_read (mem_q.mem_read),
    .mem_dst      (mem_q.dst),
    .stall        (stall)
  );

  // Stage registers: ext_stall freezes everything; a hazard stall or empty ID inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.ext_stall) begin
      ex_q  <= (bus.id_valid && !stall) ? id_ctrl : '0;
      mem_q <= {ex_q.reg_write, ex_q.mem_to_reg, ex_q.mem_read, ex_q.mem_write, ex_q.dst};
      wb_q  <= {mem_q.reg_write, mem_q.mem_to_reg, mem_q.dst};
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_regWrite  = ex_q.reg_write;
  assign bus.ex_memToReg  = ex_q.mem_to_reg;
  assign bus.ex_memRead   = ex_q.mem_read;
  assign bus.ex_memWrite  = ex_q.mem_write;
  assign bus.ex_ALUsrc    = ex_q.alu_src;
  assign bus.ex_opcode    = ex_q.opcode;
  assign bus.ex_dst       = ex_q.dst;
  assign bus.mem_regWrite = mem_q.reg_write;
  assign bus.mem_memToReg = mem_q.mem_to_reg;
  assign bus.mem_memRead  = mem_q.mem_read;
  assign bus.mem_memWrite = mem_q.mem_write;
  assign bus.mem_dst      = mem_q.dst;
  assign bus.wb_regWrite  = wb_q.reg_write;
  assign bus.wb_memToReg  = wb_q.mem_to_reg;
  assign bus.wb_dst       = wb_q.dst;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed hazard scenarios plus a random MIPS stream
// checked against an in-flight-distance reference model.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if bus();
  ctrl_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic valid, uses_rt, rw, m2r, br, mr, mw, alusrc, regdst, nodest;
    logic [5:0] opc;
    logic [4:0] rs, rt, rd;
  } ins_t;

  typedef struct packed {
    logic rw, m2r, mr, mw, alusrc;
    logic [5:0] opc;
    logic [4:0] dst;
  } rec_t;

  // In-flight instructions by distance from ID: [0]=EX, [1]=MEM, [2]=WB
  rec_t infl [0:2];

  function automatic ins_t i_nop();
    ins_t i = '0;
    return i;
  endfunction
  function automatic ins_t i_r(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    ins_t i = '0;
    i.valid = 1; i.uses_rt = 1; i.rw = 1; i.regdst = 1; i.opc = 6'h00;
    i.rd = rd; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic ins_t i_addi(logic [4:0] rt, logic [4:0] rs);
    ins_t i = '0;
    i.valid = 1; i.rw = 1; i.alusrc = 1; i.opc = 6'h08; i.rt = rt; i.rs = rs;
    return i;
  endfunction
  function automatic ins_t i_lw(logic [4:0] rt, logic [4:0] rs);
    ins_t i = '0;
    i.valid = 1; i.rw = 1; i.m2r = 1; i.mr = 1; i.alusrc = 1; i.opc = 6'h23;
    i.rt = rt; i.rs = rs;
    return i;
  endfunction
  function automatic ins_t i_sw(logic [4:0] rt, logic [4:0] rs);
    ins_t i = '0;
    i.valid = 1; i.uses_rt = 1; i.mw = 1; i.alusrc = 1; i.opc = 6'h2b; i.rt = rt; i.rs = rs;
    return i;
  endfunction
  function automatic ins_t i_beq(logic [4:0] rs, logic [4:0] rt);
    ins_t i = '0;
    i.valid = 1; i.uses_rt = 1; i.br = 1; i.opc = 6'h04; i.rs = rs; i.rt = rt;
    return i;
  endfunction
  function automatic ins_t i_jal();
    ins_t i = '0;
    i.valid = 1; i.rw = 1; i.nodest = 1; i.opc = 6'h03; i.rd = 5'd7; i.rt = 5'd9;
    return i;
  endfunction

  task automatic drive(input ins_t i, input logic ext);
    bus.ext_stall   = ext;
    bus.id_valid    = i.valid;
    bus.id_rs       = i.rs;
    bus.id_rt       = i.rt;
    bus.id_rd       = i.rd;
    bus.id_uses_rt  = i.uses_rt;
    bus.id_regWrite = i.rw;
    bus.id_memToReg = i.m2r;
    bus.id_branch   = i.br;
    bus.id_memRead  = i.mr;
    bus.id_memWrite = i.mw;
    bus.id_ALUsrc   = i.alusrc;
    bus.id_regDst   = i.regdst;
    bus.id_noDest   = i.nodest;
    bus.id_opcode   = i.opc;
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush();
    drive(i_nop(), 1'b0);
    repeat (3) adv();
  endtask

  function automatic logic [16:0] act_ex();
    return {bus.ex_regWrite, bus.ex_memToReg, bus.ex_memRead, bus.ex_memWrite,
            bus.ex_ALUsrc, bus.ex_opcode, bus.ex_dst};
  endfunction
  function automatic logic [8:0] act_mem();
    return {bus.mem_regWrite, bus.mem_memToReg, bus.mem_memRead, bus.mem_memWrite, bus.mem_dst};
  endfunction
  function automatic logic [6:0] act_wb();
    return {bus.wb_regWrite, bus.wb_memToReg, bus.wb_dst};
  endfunction

  // ---- reference model ----
  function automatic rec_t issue(input ins_t i);
    rec_t r = '0;
    r.dst    = i.nodest ? 5'd31 : (i.regdst ? i.rd : i.rt);
    r.rw     = i.rw && (r.dst != 0);
    r.m2r    = i.m2r;
    r.mr     = i.mr;
    r.mw     = i.mw;
    r.alusrc = i.alusrc;
    r.opc    = i.opc;
    return r;
  endfunction

  // A consumer must trail its producer by a minimum distance: load->ALU 2, load->branch 3,
  // ALU->branch 2, ALU->ALU 1 (forwarded). Anything closer must wait in ID.
  function automatic logic model_stall(input ins_t i, input logic ext);
    if (!i.valid || ext) return 1'b0;
    for (int d = 1; d <= 2; d++) begin
      rec_t p = infl[d-1];
      int need;
      if (!(p.mr || p.rw) || p.dst == 0) continue;
      if (!(p.dst == i.rs || (i.uses_rt && p.dst == i.rt))) continue;
      need = p.mr ? (i.br ? 3 : 2) : (i.br ? 2 : 1);
      if (d < need) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clock(input ins_t i, input logic ext, input logic st);
    if (ext) return;
    infl[2] = infl[1];
    infl[1] = infl[0];
    infl[0] = (i.valid && !st) ? issue(i) : '0;
  endtask

  function automatic ins_t rand_ins();
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] c = 5'($urandom_range(0, 7));
    ins_t i;
    case ($urandom_range(0, 6))
      0: begin i = i_lw(a, b); i.valid = 1'b0; end
      1: i = i_r(a, b, c);
      2: i = i_addi(a, b);
      3: i = i_lw(a, b);
      4: i = i_sw(a, b);
      5: i = i_beq(a, b);
      default: i = i_jal();
    endcase
    return i;
  endfunction

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0;
    drive(i_lw(5'd8, 5'd9), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({act_ex(), act_mem(), act_wb(), bus.stall} !== 34'd0) begin
      n_bad++; $display("FAIL reset_hold: got %h want 0", {act_ex(), act_mem(), act_wb(), bus.stall});
    end
    rst_n = 1'b1;
    drive(i_nop(), 1'b0);
    adv();
    n_cmp++;
    if ({act_ex(), act_mem(), act_wb(), bus.stall} !== 34'd0) begin
      n_bad++; $display("FAIL reset_release: got %h want 0", {act_ex(), act_mem(), act_wb(), bus.stall});
    end
  endtask

  task automatic test_load_use();
    flush();
    drive(i_lw(5'd8, 5'd9), 1'b0);
    #1 n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL lu_no_stall_lw: got %b want 0", bus.stall); end
    adv();
    drive(i_r(5'd9, 5'd8, 5'd10), 1'b0);
    #1 n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    adv();
    n_cmp++;
    if (act_ex() !== 17'd0) begin n_bad++; $display("FAIL lu_bubble: got %h want 0", act_ex()); end
    #1 n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_once: got %b want 0", bus.stall); end
    adv();
    n_cmp++;
    if ({act_wb(), bus.ex_dst} !== {1'b1, 1'b1, 5'd8, 5'd9}) begin
      n_bad++; $display("FAIL lu_lw_wb: got %h want %h", {act_wb(), bus.ex_dst}, {1'b1, 1'b1, 5'd8, 5'd9});
    end
    drive(i_nop(), 1'b0);
    adv();
    n_cmp++;
    if (act_wb() !== 7'd0) begin n_bad++; $display("FAIL lu_wb_bubble: got %h want 0", act_wb()); end
    adv();
    n_cmp++;
    if (act_wb() !== {1'b1, 1'b0, 5'd9}) begin
      n_bad++; $display("FAIL lu_add_wb: got %h want %h", act_wb(), {1'b1, 1'b0, 5'd9});
    end
  endtask

  task automatic test_branch();
    int cnt;
    flush();
    drive(i_addi(5'd5, 5'd1), 1'b0);
    adv();
    drive(i_beq(5'd5, 5'd6), 1'b0);
    #1 n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL br_alu_stall: got %b want 1", bus.stall); end
    adv();
    #1 n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL br_alu_release: got %b want 0", bus.stall); end
    adv();
    flush();
    drive(i_lw(5'd5, 5'd1), 1'b0);
    adv();
    drive(i_beq(5'd5, 5'd6), 1'b0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (!bus.stall) break;
      cnt++;
      adv();
    end
    n_cmp++;
    if (cnt != 2) begin n_bad++; $display("FAIL br_load_stalls: got %0d want 2", cnt); end
    adv();
    flush();
  endtask

  task automatic test_jal_zero();
    flush();
    drive(i_jal(), 1'b0);
    adv();
    drive(i_nop(), 1'b0);
    adv();
    adv();
    n_cmp++;
    if (act_wb() !== {1'b1, 1'b0, 5'd31}) begin
      n_bad++; $display("FAIL jal_wb: got %h want %h", act_wb(), {1'b1, 1'b0, 5'd31});
    end
    drive(i_addi(5'd0, 5'd3), 1'b0);
    adv();
    n_cmp++;
    if ({bus.ex_regWrite, bus.ex_dst} !== 6'd0) begin
      n_bad++; $display("FAIL zero_ex: got %h want 0", {bus.ex_regWrite, bus.ex_dst});
    end
    drive(i_nop(), 1'b0);
    adv();
    adv();
    n_cmp++;
    if (bus.wb_regWrite !== 1'b0) begin n_bad++; $display("FAIL zero_wb: got %b want 0", bus.wb_regWrite); end
    drive(i_lw(5'd0, 5'd3), 1'b0);
    adv();
    drive(i_r(5'd9, 5'd0, 5'd0), 1'b0);
    #1 n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL zero_load_stall: got %b want 0", bus.stall); end
    adv();
    flush();
  endtask

  task automatic test_ext_stall();
    flush();
    drive(i_addi(5'd3, 5'd1), 1'b0); adv();
    drive(i_addi(5'd4, 5'd1), 1'b0); adv();
    drive(i_lw(5'd8, 5'd9), 1'b0);   adv();
    drive(i_r(5'd9, 5'd8, 5'd10), 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 n_cmp++;
      if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL ext_no_stall: cyc %0d got %b want 0", k, bus.stall); end
      adv();
      n_cmp++;
      if ({bus.ex_memRead, bus.ex_dst, bus.mem_dst, bus.wb_dst} !== {1'b1, 5'd8, 5'd4, 5'd3}) begin
        n_bad++; $display("FAIL ext_hold: cyc %0d got %h want %h", k,
          {bus.ex_memRead, bus.ex_dst, bus.mem_dst, bus.wb_dst}, {1'b1, 5'd8, 5'd4, 5'd3});
      end
    end
    drive(i_r(5'd9, 5'd8, 5'd10), 1'b0);
    #1 n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL ext_then_stall: got %b want 1", bus.stall); end
    adv();
    n_cmp++;
    if ({bus.ex_regWrite, bus.ex_dst, bus.mem_dst, bus.wb_dst} !== {1'b0, 5'd0, 5'd8, 5'd4}) begin
      n_bad++; $display("FAIL ext_resume: got %h want %h",
        {bus.ex_regWrite, bus.ex_dst, bus.mem_dst, bus.wb_dst}, {1'b0, 5'd0, 5'd8, 5'd4});
    end
    adv();
    n_cmp++;
    if ({bus.ex_dst, bus.wb_dst} !== {5'd9, 5'd8}) begin
      n_bad++; $display("FAIL ext_order: got %h want %h", {bus.ex_dst, bus.wb_dst}, {5'd9, 5'd8});
    end
    flush();
  endtask

  task automatic test_async_reset();
    flush();
    drive(i_jal(), 1'b0);            adv();
    drive(i_addi(5'd7, 5'd1), 1'b0); adv();
    drive(i_lw(5'd6, 5'd2), 1'b0);
    rst_n = 1'b0;
    #1 n_cmp++;
    if ({act_ex(), act_mem(), act_wb()} !== 33'd0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", {act_ex(), act_mem(), act_wb()});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    ins_t cur;
    logic ext, est, hold;
    rec_t e0, e1, e2;
    rst_n = 1'b0;
    drive(i_nop(), 1'b0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) infl[k] = '0;
    @(negedge clk);
    cur  = i_nop();
    hold = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) cur = rand_ins();
      ext = ($urandom_range(0, 7) == 0);
      drive(cur, ext);
      #1;
      est = model_stall(cur, ext);
      n_cmp++;
      if (bus.stall !== est) begin
        n_bad++; $display("FAIL rand_stall: cyc %0d got %b want %b", c, bus.stall, est);
      end
      model_clock(cur, ext, est);
      hold = est || ext;
      adv();
      e0 = infl[0]; e1 = infl[1]; e2 = infl[2];
      n_cmp++;
      if ({act_ex(), act_mem(), act_wb()} !==
          {e0, e1.rw, e1.m2r, e1.mr, e1.mw, e1.dst, e2.rw, e2.m2r, e2.dst}) begin
        n_bad++; $display("FAIL rand_stages: cyc %0d got %h want %h", c, {act_ex(), act_mem(), act_wb()},
          {e0, e1.rw, e1.m2r, e1.mr, e1.mw, e1.dst, e2.rw, e2.m2r, e2.dst});
      end
    end
  endtask

  initial begin
    drive(i_nop(), 1'b0);
    test_reset();
    test_load_use();
    test_branch();
    test_jal_zero();
    test_ext_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
